qtz_chunk_sequencer: RTL and testbench

//   Sequences the quantizer input mux: steps the chunk select through all feature chunks,
//   one chunk per accepted transfer, with a valid/ready handshake to the quantizer datapath.

---
 rtl/qtz_pkg.sv | 34 +++
 rtl/qtz_chunk_sequencer.sv | 126 ++++++++++++
 tb/tb_qtz_chunk_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qtz_pkg.sv
// qtz_pkg: shared constants and types for the quantizer chunk sequencer.
// The chunk geometry is fixed here; everything else is derived from
// FEATURE_COUNT and FEATURES_PER_CC so the two stay consistent.
package qtz_pkg;

   // Input features per sample and mux lanes per chunk.
   localparam int FEATURE_COUNT   = 617;
   localparam int FEATURES_PER_CC = 155;

   // Derived chunk geometry.
   localparam int NUM_CHUNKS = (FEATURE_COUNT + FEATURES_PER_CC - 1) / FEATURES_PER_CC;
   localparam int CTR_W      = $clog2(NUM_CHUNKS);
   localparam int LAST_LANES = FEATURE_COUNT - (NUM_CHUNKS - 1) * FEATURES_PER_CC;

   // Chunk select driven to the quantizer input mux.
   typedef logic [CTR_W-1:0] chunk_sel_t;

   // Index of the final chunk of a sample.
   localparam chunk_sel_t LAST_CHUNK = chunk_sel_t'(NUM_CHUNKS - 1);

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } qtz_seq_state_t;

   // Lane masks: every lane live, or only the low LAST_LANES lanes live on
   // the final chunk (upper lanes carry zero padding).
   localparam logic [FEATURES_PER_CC-1:0] FULL_LANE_MASK = '1;
   localparam logic [FEATURES_PER_CC-1:0] LAST_LANE_MASK =
      {{(FEATURES_PER_CC - LAST_LANES){1'b0}}, {LAST_LANES{1'b1}}};

endpackage : qtz_pkg

// File: rtl/qtz_chunk_sequencer.sv
// qtz_chunk_sequencer: steps the quantizer input-mux chunk select through
// every feature chunk of one sample, one chunk per valid/ready handshake.
// Select and valid are held stable under backpressure. Abort cancels the
// sample without a done pulse. All outputs come from registered state.
//
// Optional build macro: QTZ_LANE_MASK_EN adds a registered lane_mask output
// that marks which mux lanes of the current chunk carry real features.
module qtz_chunk_sequencer
   import qtz_pkg::*;
(
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       out_ready,
   output chunk_sel_t                 ctr,
   output logic                       out_valid,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done
`ifdef QTZ_LANE_MASK_EN
   ,
   output logic [FEATURES_PER_CC-1:0] lane_mask
`endif
);

   qtz_seq_state_t state_q, state_d;
   chunk_sel_t     ctr_q, ctr_d;
   logic           valid_q, valid_d;
   logic           handshake;

   assign handshake = valid_q && out_ready;

   // Next-state and chunk counter; abort overrides every other transition.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      ctr_d   = ctr_q;
      valid_d = valid_q;

      if (abort) begin
         state_d = IDLE;
         ctr_d   = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  ctr_d   = '0;
                  valid_d = 1'b1;
               end
            end
            RUN: begin
               if (handshake) begin
                  if (ctr_q == LAST_CHUNK) begin
                     state_d = DONE;
                     ctr_d   = '0;
                     valid_d = 1'b0;
                  end else begin
                     ctr_d = ctr_q + chunk_sel_t'(1);
                  end
               end
            end
            DONE: begin
               // One-cycle completion marker; start here is deliberately dropped.
               state_d = IDLE;
               ctr_d   = '0;
               valid_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               ctr_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State, select and valid registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         ctr_q   <= ctr_d;
         valid_q <= valid_d;
      end
   end

   // Outputs decoded from registered state only.
   assign ctr       = ctr_q;
   assign out_valid = valid_q;
   assign out_last  = valid_q && (ctr_q == LAST_CHUNK);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

`ifdef QTZ_LANE_MASK_EN
   logic [FEATURES_PER_CC-1:0] lane_mask_q, lane_mask_d;

   // Lane mask follows the next select so it lines up with ctr each cycle.
   always_comb begin
      lane_mask_d = '0;
      if (valid_d) begin
         lane_mask_d = (ctr_d == LAST_CHUNK) ? LAST_LANE_MASK : FULL_LANE_MASK;
      end
   end

   // Lane mask register, cleared with the rest of the sequencer.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lane_mask_q <= '0;
      end else begin
         lane_mask_q <= lane_mask_d;
      end
   end

   assign lane_mask = lane_mask_q;
`endif

endmodule : qtz_chunk_sequencer

// File: tb/tb_qtz_chunk_sequencer.sv
// tb_qtz_chunk_sequencer: self-checking bench for qtz_chunk_sequencer.
// A sample is modelled as a position: 0 idle, 1..4 presenting chunk pos-1,
// 5 the done cycle. Expected outputs are derived from that position alone.
// Honours QTZ_LANE_MASK_EN to check lane_mask as well.
module tb_qtz_chunk_sequencer;
   import qtz_pkg::*;

`ifdef QTZ_LANE_MASK_EN
   localparam int OBS_W = 6 + FEATURES_PER_CC;
`else
   localparam int OBS_W = 6;
`endif

   logic       clk = 1'b0;
   logic       nrst;
   logic       start;
   logic       abort;
   logic       out_ready;
   chunk_sel_t ctr;
   logic       out_valid;
   logic       out_last;
   logic       busy;
   logic       done;
`ifdef QTZ_LANE_MASK_EN
   logic [FEATURES_PER_CC-1:0] lane_mask;
`endif

   int n_vec = 0;
   int n_err = 0;
   int m_pos = 0;

   qtz_chunk_sequencer dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .abort     (abort),
      .out_ready (out_ready),
      .ctr       (ctr),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
`ifdef QTZ_LANE_MASK_EN
      ,
      .lane_mask (lane_mask)
`endif
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {busy, done, out_valid, out_last, ctr[1:0], lane_mask}.
   function automatic logic [OBS_W-1:0] obs_vec();
      logic [OBS_W-1:0] v;
`ifdef QTZ_LANE_MASK_EN
      v = {busy, done, out_valid, out_last, ctr, lane_mask};
`else
      v = {busy, done, out_valid, out_last, ctr};
`endif
      return v;
   endfunction

   // Expected outputs from the sample position.
   function automatic logic [OBS_W-1:0] exp_vec();
      logic [OBS_W-1:0] v;
      logic       e_busy, e_done, e_valid, e_last;
      logic [1:0] e_ctr;
      e_valid = (m_pos >= 1 && m_pos <= 4);
      e_busy  = (m_pos != 0);
      e_done  = (m_pos == 5);
      e_last  = (m_pos == 4);
      e_ctr   = e_valid ? 2'(m_pos - 1) : 2'd0;
`ifdef QTZ_LANE_MASK_EN
      begin
         logic [FEATURES_PER_CC-1:0] e_mask;
         for (int i = 0; i < FEATURES_PER_CC; i++) begin
            e_mask[i] = e_valid && ((m_pos != 4) || (i < 152));
         end
         v = {e_busy, e_done, e_valid, e_last, e_ctr, e_mask};
      end
`else
      v = {e_busy, e_done, e_valid, e_last, e_ctr};
`endif
      return v;
   endfunction

   // Reference model: advance one clock given the inputs seen at that edge.
   task automatic model_step(input logic s, input logic a, input logic r);
      if (a)                          m_pos = 0;
      else if (m_pos == 0)            m_pos = s ? 1 : 0;
      else if (m_pos == 5)            m_pos = 0;
      else if (r)                     m_pos = m_pos + 1;
   endtask

   // Drive inputs on the falling edge, step the model on the rising edge,
   // and leave time 1 unit past the edge for sampling.
   task automatic tick(input logic s, input logic a, input logic r);
      @(negedge clk);
      start = s; abort = a; out_ready = r;
      @(posedge clk);
      model_step(s, a, r);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      m_pos = 0;
      #2;
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_assert: got %h expected %h", obs_vec(), exp_vec());
      end
      @(negedge clk); nrst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_idle cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_stream();
      int exp_ctr [4] = '{0, 1, 2, 3};
      tick(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            n_vec++;
            if (ctr !== 2'(exp_ctr[i]) || out_valid !== 1'b1 || out_last !== (i == 3)) begin
               n_err++;
               $display("FAIL stream_chunk%0d: got ctr=%0d v=%b l=%b expected ctr=%0d v=1 l=%b",
                        i, ctr, out_valid, out_last, exp_ctr[i], (i == 3));
            end
         end
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL stream cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
         tick(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_backpressure();
      logic r_seq [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0, r_seq[i]);
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL backpressure cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_start_held();
      int n_done = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, 1'b0, 1'b1);
         if (done) n_done++;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL start_held cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      n_vec++;
      if (n_done !== 2) begin
         n_err++;
         $display("FAIL start_held_done_count: got %0d expected 2", n_done);
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL start_held_drain cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_abort();
      // Abort at ctr=2.
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b1);
      n_vec++;
      if (obs_vec() !== exp_vec() || ctr !== 2'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_mid: got %h expected %h", obs_vec(), exp_vec());
      end
      // Abort coincident with the final handshake.
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (obs_vec() !== exp_vec() || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_final cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
         tick(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(3) == 0), ($urandom_range(19) == 0), ($urandom_range(2) != 0));
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (ctr !== 2'd3 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL async_setup: got ctr=%0d v=%b expected ctr=3 v=1", ctr, out_valid);
      end
      #2 nrst = 1'b0;
      m_pos = 0;
      #1;
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL async_reset: got %h expected %h", obs_vec(), exp_vec());
      end
      @(negedge clk); nrst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL async_after cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_start_held();
      test_abort();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_qtz_chunk_sequencer
